// File: rtl/sdram_burst_reader.sv
// sdram_burst_reader: Avalon-MM burst read master feeding an Avalon-ST source.
// Reads ctrl_length 16-bit words starting at ctrl_base_addr. It issues bursts
// only when the response FIFO has room for them, buffers the returned words and
// streams them out with sop/eop framing.
// Optional build macro SDRAM_BURST_READER_BOUNDARY_EN: when defined, no burst
// crosses a BURST_MAX-word aligned address boundary.
//
// Handshakes:
//   avm: a request is held stable while avm_read=1 and avm_waitrequest=1. It
//        is accepted on the first cycle with avm_read=1 and avm_waitrequest=0.
//   src: a word transfers on any cycle with src_valid=1 and src_ready=1. While
//        src_valid=1 the data and framing do not change until that transfer.
module sdram_burst_reader #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 16,
    parameter int BURST_MAX  = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                         clock_clk,
    input  logic                         clock_sreset_reset_n,
    input  logic                         ctrl_start,
    input  logic [ADDR_W-1:0]            ctrl_base_addr,
    input  logic [LEN_W-1:0]             ctrl_length,
    output logic                         ctrl_busy,
    output logic                         ctrl_done,
    output logic [ADDR_W-1:0]            avm_address,
    output logic                         avm_read,
    output logic [$clog2(BURST_MAX):0]   avm_burstcount,
    input  logic                         avm_waitrequest,
    input  logic [DATA_W-1:0]            avm_readdata,
    input  logic                         avm_readdatavalid,
    output logic [DATA_W-1:0]            src_data,
    output logic                         src_valid,
    input  logic                         src_ready,
    output logic                         src_sop,
    output logic                         src_eop,
    output logic [1:0]                   dbg_state
);

    localparam int BC_W    = $clog2(BURST_MAX) + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BYTES   = DATA_W / 8;
    localparam int OFF_LSB = $clog2(BYTES);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Control state
    logic [1:0]        state;
    logic [LEN_W-1:0]  len_r;        // latched transfer length
    logic [ADDR_W-1:0] addr_r;       // address of the next burst to issue
    logic [LEN_W-1:0]  words_to_req; // words not yet covered by an accepted burst
    logic [CNT_W-1:0]  in_flight;    // accepted words whose data has not arrived
    logic [LEN_W-1:0]  pop_cnt;      // index of the word at the FIFO head
    logic              busy_r;
    logic              done_r;
    logic              rd_r;
    logic [ADDR_W-1:0] addr_o;
    logic [BC_W-1:0]   bc_o;

    // Response FIFO
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              xfer_active;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              accept;
    logic              issue;
    logic [CNT_W-1:0]  credit;
    logic [BC_W-1:0]   limit;
    logic [BC_W-1:0]   burst;
    logic [ADDR_W-1:0] addr_step;

    assign xfer_active = (state == ST_REQ) || (state == ST_DRAIN);
    // Responses are only meaningful while a transfer is running.
    assign push        = avm_readdatavalid && xfer_active;
    assign fifo_empty  = (count == '0);
    assign pop         = !fifo_empty && src_ready;
    assign accept      = rd_r && !avm_waitrequest;
    // Room in the FIFO that is not already promised to outstanding reads.
    assign credit      = DEPTH_C - count - in_flight;
    assign addr_step   = ADDR_W'(bc_o) << OFF_LSB;

`ifdef SDRAM_BURST_READER_BOUNDARY_EN
    localparam int OFF_W = $clog2(BURST_MAX);
    logic [OFF_W-1:0] word_off;
    // Shorten the burst so it ends on the next BURST_MAX-word boundary.
    assign word_off = addr_r[OFF_LSB +: OFF_W];
    assign limit    = BC_W'(BURST_MAX) - BC_W'(word_off);
`else
    assign limit    = BC_W'(BURST_MAX);
`endif

    assign burst = (words_to_req < LEN_W'(limit)) ? BC_W'(words_to_req) : limit;
    assign issue = (state == ST_REQ) && !rd_r && (words_to_req != '0)
                   && (credit >= CNT_W'(burst));

    // FSM, request generation and transfer bookkeeping
    always_ff @(posedge clock_clk) begin
        if (!clock_sreset_reset_n) begin
            state        <= ST_IDLE;
            len_r        <= '0;
            addr_r       <= '0;
            words_to_req <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rd_r         <= 1'b0;
            addr_o       <= '0;
            bc_o         <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        len_r        <= ctrl_length;
                        addr_r       <= ctrl_base_addr;
                        words_to_req <= ctrl_length;
                        busy_r       <= 1'b1;
                        state        <= (ctrl_length == '0) ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (accept) begin
                        rd_r         <= 1'b0;
                        addr_r       <= addr_r + addr_step;
                        words_to_req <= words_to_req - LEN_W'(bc_o);
                        if (words_to_req == LEN_W'(bc_o)) begin
                            state <= ST_DRAIN;
                        end
                    end else if (issue) begin
                        rd_r   <= 1'b1;
                        addr_o <= addr_r;
                        bc_o   <= burst;
                    end
                end
                ST_DRAIN: begin
                    if ((in_flight == '0) && (pop_cnt == len_r)) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            endcase
        end
    end

    // Outstanding-word and output-index counters
    always_ff @(posedge clock_clk) begin
        if (!clock_sreset_reset_n) begin
            in_flight <= '0;
            pop_cnt   <= '0;
        end else if (state == ST_IDLE) begin
            in_flight <= '0;
            pop_cnt   <= '0;
        end else begin
            in_flight <= in_flight + (accept ? CNT_W'(bc_o) : '0)
                                   - (push ? CNT_W'(1) : '0);
            if (pop) begin
                pop_cnt <= pop_cnt + LEN_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy; reset flushes any buffered words
    always_ff @(posedge clock_clk) begin
        if (!clock_sreset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write; the read side is show-ahead from rd_ptr
    always_ff @(posedge clock_clk) begin
        if (push) begin
            mem[wr_ptr] <= avm_readdata;
        end
    end

    // The credit check keeps pushes from ever landing on a full FIFO.
    a_no_overflow: assert property (@(posedge clock_clk)
        disable iff (!clock_sreset_reset_n) !(push && (count == DEPTH_C)));

    assign ctrl_busy      = busy_r;
    assign ctrl_done      = done_r;
    assign avm_read       = rd_r;
    assign avm_address    = addr_o;
    assign avm_burstcount = bc_o;
    assign src_valid      = !fifo_empty;
    assign src_data       = fifo_empty ? '0 : mem[rd_ptr];
    assign src_sop        = !fifo_empty && (pop_cnt == '0);
    assign src_eop        = !fifo_empty && (pop_cnt == (len_r - LEN_W'(1)));
    assign dbg_state      = state;

endmodule

// File: doc/sdram_burst_reader.md
Name: sdram_burst_reader

Overview:
- Avalon-MM burst read master inside the inference system. It streams a contiguous block of 16-bit words from the board SDRAM (weights or feature maps) into the CNN datapath as an Avalon-ST source.
- Sits directly upstream of the compute stage and attaches to the SDRAM controller slave through the system interconnect.
- Software or a sequencer supplies base address and length. The block issues credit-limited bursts, buffers responses in an internal FIFO and handles backpressure.

Parameters:
- ADDR_W, 32, byte address width of the Avalon-MM master.
- DATA_W, 16, word width; matches the SDRAM data bus.
- LEN_W, 16, width of the word-count field.
- BURST_MAX, 8, maximum burstcount per request; power of 2.
- FIFO_DEPTH, 32, response FIFO depth in words; power of 2, at least 2*BURST_MAX.

Ports:
- clock_clk  in  1  system clock
- clock_sreset_reset_n  in  1  synchronous active-low reset
- ctrl_start  in  1  one-cycle start pulse
- ctrl_base_addr  in  ADDR_W  byte start address; bits [0] must be 0
- ctrl_length  in  LEN_W  number of words to read
- ctrl_busy  out  1  transfer in progress
- ctrl_done  out  1  one-cycle completion pulse
- avm_address  out  ADDR_W  burst byte address
- avm_read  out  1  read request
- avm_burstcount  out  log2(BURST_MAX)+1  words in burst
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  response data
- avm_readdatavalid  in  1  response valid
- src_data  out  DATA_W  stream data
- src_valid  out  1  stream valid
- src_ready  in  1  stream ready
- src_sop  out  1  first word of transfer
- src_eop  out  1  last word of transfer

Behaviour:
- Clock and reset: one clock, clock_clk. Reset clock_sclock_sreset_reset_n is synchronous and active-low.
- Reset values: all outputs 0. FIFO empty, all counters 0, FSM in IDLE.
- FSM states: IDLE, REQ, DRAIN, DONE.
- IDLE:
  - ctrl_start=1 latches base address and length, sets ctrl_busy=1.
  - If length=0, go to DONE (no reads issued). Otherwise go to REQ.
- REQ:
  - Burst size b = min(BURST_MAX, words_to_request).
  - Request is issued only when FIFO free slots minus in-flight words >= b (credit check). Otherwise avm_read stays 0.
  - While avm_read=1 and avm_waitrequest=1, address, burstcount and read are held stable.
  - The request is accepted on the cycle avm_read=1 and avm_waitrequest=0. On acceptance: address += b*DATA_W/8, words_to_request -= b, in_flight += b.
  - When words_to_request reaches 0, go to DRAIN.
- Response path:
  - Each avm_readdatavalid pushes one word into the FIFO and decrements in_flight.
  - Overflow is impossible by construction. A push with the FIFO full is a design error; flag it with a simulation assertion.
- Stream output:
  - src_valid = FIFO not empty. A word pops when src_valid=1 and src_ready=1.
  - src_sop is set on word index 0. src_eop is set on word index length-1. For length=1, both are set on the same word.
  - Latency from readdatavalid to src_valid is 1 cycle (registered FIFO write, show-ahead read).
- DRAIN: wait until in_flight=0 and the last word has popped, then go to DONE.
- DONE: ctrl_done=1 for one cycle, ctrl_busy=0, return to IDLE.
- ctrl_start while busy: ignored; no latching, no error.
- Simultaneous push and pop: both happen; occupancy is unchanged.
- Reset mid-transfer: aborts immediately and flushes the FIFO. The slave is reset by the same synchronous reset, so no stale responses arrive.
- readdatavalid in IDLE or DONE: ignored.

Optional Feature:
- Macro: SDRAM_BURST_READER_BOUNDARY_EN.
- Defined: a burst never crosses an address boundary aligned to BURST_MAX*DATA_W/8 bytes. b = min(BURST_MAX - word_offset_in_block, words_to_request), so only the first burst can be short due to misalignment.
- Undefined: b = min(BURST_MAX, words_to_request) regardless of alignment.

Test Plan:
- base=0x100, length=20, src_ready=1, no waitrequest -> bursts 8,8,4 at 0x100, 0x110, 0x120; 20 words out in order; sop on word 0, eop on word 19; ctrl_done pulses once.
- length=0 -> no avm_read asserted; ctrl_done pulses 2 cycles after start.
- length=64, src_ready=0 for 200 cycles -> exactly 32 words requested (FIFO_DEPTH); no further avm_read until pops free credit; no overflow.
- waitrequest=1 for 5 cycles on the 2nd burst -> address, burstcount and read held constant all 5 cycles; data sequence unaffected.
- Reset asserted at word 10 of a 40-word transfer, then a new start with length=3 -> all outputs 0 after reset; new transfer yields 3 words with correct sop and eop.
- BOUNDARY_EN defined, base=0x106, length=12 -> bursts 5 (0x106), 7 (0x110); undefined -> bursts 8, 4.
